// File: rtl/int_mult_result_buffer.sv
// ---------------------------------------------------------------------------
// int_mult_result_buffer
//
// Purpose:
//   Output buffer behind the shared integer multiplier. Each valid result and
//   its tag are stored in a small FIFO. They wait there until the cluster
//   interconnect acknowledges the head entry. This decouples the single-cycle
//   multiplier from interconnect backpressure. The block also reports whether
//   the FIFO is full, and holds a sticky error bit that records any result
//   which was dropped.
//
// Ports:
//   clk_i     in   1          clock
//   rst_ni    in   1          asynchronous active-low reset
//   Valid_i   in   1          multiplier result valid this cycle
//   Res_i     in   DSP_WIDTH  multiplier result
//   Tag_i     in   TAG_WIDTH  tag accompanying the result
//   Ready_o   out  1          buffer can accept a result this cycle
//   Valid_o   out  1          head entry valid towards the interconnect
//   Res_o     out  DSP_WIDTH  head entry result (0 when Valid_o=0)
//   Tag_o     out  TAG_WIDTH  head entry tag (0 when Valid_o=0)
//   Ack_i     in   1          interconnect consumes the head entry
//   Clear_i   in   1          synchronous flush of entries and sticky error
//   Status_o  out  2          bit0 = full, bit1 = sticky drop error
//
// Optional feature (macro INT_MULT_RESULT_BUFFER_BYPASS_EN):
//   When the FIFO is empty, an incoming result is presented combinationally
//   in the same cycle. If the result is also acknowledged in that cycle, it
//   is never written into the FIFO. Ready_o stays registered-only.
// ---------------------------------------------------------------------------
module int_mult_result_buffer #(
  parameter int DSP_WIDTH = 32,
  parameter int TAG_WIDTH = 5,
  parameter int DEPTH     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 Valid_i,
  input  logic [DSP_WIDTH-1:0] Res_i,
  input  logic [TAG_WIDTH-1:0] Tag_i,
  output logic                 Ready_o,
  output logic                 Valid_o,
  output logic [DSP_WIDTH-1:0] Res_o,
  output logic [TAG_WIDTH-1:0] Tag_o,
  input  logic                 Ack_i,
  input  logic                 Clear_i,
  output logic [1:0]           Status_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [CNT_W-1:0]     count_next;
  logic                 err_reg;

  logic [DSP_WIDTH-1:0] res_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic drop;
  logic bypass_hit;
  logic bypass_take;

  logic                 head_valid;
  logic [DSP_WIDTH-1:0] head_res;
  logic [TAG_WIDTH-1:0] head_tag;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef INT_MULT_RESULT_BUFFER_BYPASS_EN
  // An empty FIFO forwards the incoming result straight to the outputs.
  assign bypass_hit  = empty && Valid_i;
  assign bypass_take = bypass_hit && Ack_i;
`else
  assign bypass_hit  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  // Ready_o depends only on registered state. It never depends on Ack_i.
  // A full buffer therefore refuses a push, even when a pop happens in the
  // same cycle.
  assign Ready_o = !full;

  // A result that is consumed through the bypass is never written.
  assign push = Valid_i && !full && !bypass_take && !Clear_i;
  // The pop is gated on stored occupancy. A bypassed pop then cannot
  // underflow the count.
  assign pop  = Ack_i && !empty && !Clear_i;
  // Results presented together with Clear_i are discarded silently.
  assign drop = Valid_i && full && !Clear_i;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (Clear_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      if (drop) err_reg <= 1'b1;
    end
  end

  // Storage is not reset. Whenever the FIFO is empty, its contents are masked
  // at the outputs.
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem[wr_ptr_reg] <= Res_i;
      tag_mem[wr_ptr_reg] <= Tag_i;
    end
  end

  always_comb begin
    head_valid = !empty;
    head_res   = res_mem[rd_ptr_reg];
    head_tag   = tag_mem[rd_ptr_reg];
    if (bypass_hit) begin
      head_valid = 1'b1;
      head_res   = Res_i;
      head_tag   = Tag_i;
    end
  end

  assign Valid_o  = head_valid;
  assign Res_o    = head_valid ? head_res : '0;
  assign Tag_o    = head_valid ? head_tag : '0;
  assign Status_o = {err_reg, full};

endmodule

// File: tb/tb_int_mult_result_buffer.sv
module tb_int_mult_result_buffer;

  localparam int DW    = 32;
  localparam int TW    = 5;
  localparam int DEPTH = 2;
  localparam int OW    = 2 + DW + TW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] res_in = '0;
  logic [TW-1:0] tag_in = '0;
  logic          ack = 1'b0;
  logic          clr = 1'b0;
  logic          ready;
  logic          valid_out;
  logic [DW-1:0] res_out;
  logic [TW-1:0] tag_out;
  logic [1:0]    status;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of {res, tag} entries and a sticky error flag.
  logic [DW+TW-1:0] q[$];
  logic             err_m;

  int_mult_result_buffer #(.DSP_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_n), .Valid_i(valid_in), .Res_i(res_in),
    .Tag_i(tag_in), .Ready_o(ready), .Valid_o(valid_out), .Res_o(res_out),
    .Tag_o(tag_out), .Ack_i(ack), .Clear_i(clr), .Status_o(status)
  );

  always #5 clk = ~clk;

  function automatic logic [OW-1:0] model_out();
    logic          v;
    logic [DW-1:0] r;
    logic [TW-1:0] t;
    v = (q.size() != 0);
    r = '0;
    t = '0;
    if (v) {r, t} = q[0];
    return {q.size() != DEPTH, v, r, t, err_m, q.size() == DEPTH};
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] r, input logic [TW-1:0] t,
                       input logic a, input logic c);
    valid_in = v; res_in = r; tag_in = t; ack = a; clr = c;
  endtask

  // Advance one clock edge, then apply the same edge to the model.
  task automatic step();
    logic          v, a, c;
    logic [DW-1:0] r;
    logic [TW-1:0] t;
    int            sz;
    v = valid_in; a = ack; c = clr; r = res_in; t = tag_in;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      sz = q.size();
      if (a && sz > 0) void'(q.pop_front());
      if (v && sz < DEPTH) q.push_back({r, t});
      if (v && sz == DEPTH) err_m = 1'b1;
    end
  endtask

  task automatic flush();
    drive(0, '0, '0, 0, 1);
    step();
    drive(0, '0, '0, 0, 0);
  endtask

  task automatic test_reset();
    logic [OW-1:0] obs;
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0);
    q.delete(); err_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    obs = {ready, valid_out, res_out, tag_out, status};
    checks++;
    if (obs !== {1'b1, 1'b0, {DW{1'b0}}, {TW{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL reset_state got=%h want=%h", obs, model_out());
    end
    rst_n = 1'b1;
    step();
    obs = {ready, valid_out, res_out, tag_out, status};
    checks++;
    if (obs !== model_out()) begin
      errors++;
      $display("FAIL reset_idle got=%h want=%h", obs, model_out());
    end
  endtask

  task automatic test_single_push();
    drive(1, 32'hDEADBEEF, 5'd3, 1, 0);
    step();
    checks++;
    if ({valid_out, res_out, tag_out} !== {1'b1, 32'hDEADBEEF, 5'd3}) begin
      errors++;
      $display("FAIL single_push_out got=%b/%h/%0d want=1/deadbeef/3", valid_out, res_out, tag_out);
    end
    drive(0, '0, '0, 1, 0);
    step();
    checks++;
    if ({valid_out, res_out, tag_out} !== {1'b0, 32'h0, 5'd0}) begin
      errors++;
      $display("FAIL single_push_drain got=%b/%h/%0d want=0/0/0", valid_out, res_out, tag_out);
    end
  endtask

  task automatic test_fill_drop();
    flush();
    drive(1, 32'h11, 5'd1, 0, 0); step();
    drive(1, 32'h22, 5'd2, 0, 0); step();
    checks++;
    if ({status, ready} !== {2'b01, 1'b0}) begin
      errors++;
      $display("FAIL fill_full got status=%b ready=%b want status=01 ready=0", status, ready);
    end
    drive(1, 32'h33, 5'd3, 0, 0); step();
    checks++;
    if ({status, tag_out} !== {2'b11, 5'd1}) begin
      errors++;
      $display("FAIL fill_drop got status=%b tag=%0d want status=11 tag=1", status, tag_out);
    end
    drive(0, '0, '0, 1, 0); step();
    checks++;
    if ({valid_out, tag_out, res_out} !== {1'b1, 5'd2, 32'h22}) begin
      errors++;
      $display("FAIL fill_second got v=%b tag=%0d res=%h want v=1 tag=2 res=22", valid_out, tag_out, res_out);
    end
    step();
    checks++;
    if ({valid_out, status} !== {1'b0, 2'b10}) begin
      errors++;
      $display("FAIL fill_empty got v=%b status=%b want v=0 status=10", valid_out, status);
    end
    drive(0, '0, '0, 0, 0);
  endtask

  task automatic test_full_pop_push();
    flush();
    drive(1, 32'h44, 5'd4, 0, 0); step();
    drive(1, 32'h55, 5'd5, 0, 0); step();
    drive(1, 32'h66, 5'd6, 1, 0); step();
    checks++;
    if ({ready, status, tag_out, valid_out} !== {1'b1, 2'b10, 5'd5, 1'b1}) begin
      errors++;
      $display("FAIL full_pop_push got ready=%b status=%b tag=%0d v=%b want 1/10/5/1", ready, status, tag_out, valid_out);
    end
    drive(0, '0, '0, 1, 0); step();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_push_count got v=%b want v=0 (only one entry left)", valid_out);
    end
    drive(0, '0, '0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] want[4];
    want = '{5'd7, 5'd8, 5'd9, 5'd10};
    flush();
    drive(1, 32'h700, 5'd7, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({valid_out, tag_out, status[0]} !== {1'b1, want[i], 1'b0}) begin
        errors++;
        $display("FAIL back_to_back[%0d] got v=%b tag=%0d full=%b want v=1 tag=%0d full=0",
                 i, valid_out, tag_out, status[0], want[i]);
      end
      if (i < 3) drive(1, 32'h700 + 32'(i + 1), want[i] + 5'd1, 1, 0);
      else       drive(0, '0, '0, 1, 0);
      step();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_end got v=%b want 0", valid_out);
    end
    drive(0, '0, '0, 0, 0);
  endtask

  task automatic test_clear();
    flush();
    drive(1, 32'h1, 5'd1, 0, 0); step();
    drive(1, 32'h2, 5'd2, 0, 0); step();
    drive(1, 32'h3, 5'd3, 0, 0); step();
    drive(1, 32'h4, 5'd4, 1, 1); step();
    checks++;
    if ({valid_out, status, ready, res_out, tag_out} !== {1'b0, 2'b00, 1'b1, 32'h0, 5'd0}) begin
      errors++;
      $display("FAIL clear got v=%b status=%b ready=%b want v=0 status=00 ready=1", valid_out, status, ready);
    end
    drive(0, '0, '0, 0, 0); step();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL clear_not_stored got v=%b want 0", valid_out);
    end
  endtask

  task automatic test_async_reset();
    flush();
    drive(1, 32'hA, 5'd10, 0, 0); step();
    drive(1, 32'hB, 5'd11, 0, 0); step();
    drive(1, 32'hC, 5'd12, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    q.delete(); err_m = 1'b0;
    checks++;
    if ({valid_out, status, ready} !== {1'b0, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL async_reset got v=%b status=%b ready=%b want v=0 status=00 ready=1", valid_out, status, ready);
    end
    drive(1, 32'h6, 5'd6, 0, 0);
    #1 rst_n = 1'b1;
    step();
    checks++;
    if ({valid_out, tag_out, res_out} !== {1'b1, 5'd6, 32'h6}) begin
      errors++;
      $display("FAIL async_reset_push got v=%b tag=%0d want v=1 tag=6", valid_out, tag_out);
    end
    drive(0, '0, '0, 0, 0);
  endtask

  task automatic test_random();
    logic [OW-1:0] obs;
    flush();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom, TW'($urandom),
            $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 4);
      step();
      obs = {ready, valid_out, res_out, tag_out, status};
      checks++;
      if (obs !== model_out()) begin
        errors++;
        $display("FAIL random[%0d] got=%h want=%h", i, obs, model_out());
      end
    end
    drive(0, '0, '0, 0, 0);
  endtask

  initial begin
    err_m = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drop();
    test_full_pop_push();
    test_back_to_back();
    test_clear();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
